tcam_ctrl: RTL and testbench

- Command sequencer in front of the TCAM array `mem_arr` (WORD_WIDTH × WORD_NUM).
- Accepts write, clear, search and flush commands over a valid/ready interface and drives the array's word/mask/addr/opcode/req/clr inputs.
- Tracks which entries are valid and priority-encodes search matches into a lowest-index hit.
- Returns one response per command over a valid/ready interface.

---
 rtl/tcam_pkg.sv | 24 ++
 rtl/tcam_prio_enc.sv | 29 ++
 rtl/tcam_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_tcam_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared types for the TCAM command sequencer: command opcodes, FSM states
// and the address-width helper used to size index ports.
package tcam_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_SEARCH = 2'b10,
        OP_FLUSH  = 2'b11
    } tcam_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SEARCH,
        ST_FLUSH,
        ST_RESP
    } tcam_state_e;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index priority encoder for a match-line vector, with hit and
// multiple-hit flags. Purely combinational.
module tcam_prio_enc
    import tcam_pkg::*;
#(
    parameter int  WORD_NUM = 8,
    localparam int ADDR_W   = addr_w(WORD_NUM)
) (
    input  logic [WORD_NUM-1:0] vec_i,
    output logic [ADDR_W-1:0]   idx_o,
    output logic                hit_o,
    output logic                multi_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WORD_NUM - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = ADDR_W'(i);
            end
        end
    end

    assign hit_o   = |vec_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(vec_i & (vec_i - {{(WORD_NUM-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/tcam_ctrl.sv
// Command sequencer for the mem_arr TCAM: issues write/clear/search/flush
// cycles, tracks valid entries and returns one response per command.
module tcam_ctrl
    import tcam_pkg::*;
#(
    parameter int  WORD_WIDTH = 8,
    parameter int  WORD_NUM   = 8,
    parameter int  SEARCH_LAT = 1,
    localparam int ADDR_W     = addr_w(WORD_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WORD_WIDTH-1:0] cmd_key,
    input  logic [WORD_WIDTH-1:0] cmd_mask,
    input  logic [ADDR_W-1:0]     cmd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic                  rsp_multi,
    output logic [ADDR_W-1:0]     rsp_idx,
    output logic [WORD_NUM-1:0]   rsp_match_vec,
    output logic [ADDR_W:0]       occupancy,
    output logic [WORD_WIDTH-1:0] mem_word,
    output logic [WORD_WIDTH-1:0] mem_mask,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_opcode,
    output logic                  mem_req,
    output logic                  mem_clr,
    input  logic [WORD_NUM-1:0]   mem_matched
);

    localparam int OCC_W = ADDR_W + 1;
    localparam int CNT_W = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;

    tcam_state_e           state_q, state_d;
    logic [WORD_NUM-1:0]   valid_map_q, valid_map_d;
    logic [WORD_NUM-1:0]   match_vec_q, match_vec_d;
    logic [OCC_W-1:0]      occupancy_q, occupancy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WORD_WIDTH-1:0] mem_word_q, mem_word_d;
    logic [WORD_WIDTH-1:0] mem_mask_q, mem_mask_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  mem_opcode_q, mem_opcode_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_clr_q, mem_clr_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        valid_map_d  = valid_map_q;
        match_vec_d  = match_vec_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        mem_word_d   = mem_word_q;
        mem_mask_d   = mem_mask_q;
        mem_addr_d   = mem_addr_q;
        mem_opcode_d = mem_opcode_q;
        mem_req_d    = mem_req_q;
        mem_clr_d    = mem_clr_q;

        occupancy_d = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            occupancy_d = occupancy_d + OCC_W'(valid_map_q[i]);
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mem_req_d    = 1'b1;
                    mem_opcode_d = 1'b0;
                    mem_clr_d    = 1'b0;
                    mem_word_d   = cmd_key;
                    mem_mask_d   = cmd_mask;
                    mem_addr_d   = cmd_addr;
                    match_vec_d  = '0;
                    unique case (tcam_op_e'(cmd_op))
                        OP_WRITE: begin
                            state_d               = ST_ISSUE;
                            valid_map_d[cmd_addr] = 1'b1;
                        end
                        OP_CLEAR: begin
                            state_d               = ST_ISSUE;
                            mem_clr_d             = 1'b1;
                            valid_map_d[cmd_addr] = 1'b0;
                        end
                        OP_SEARCH: begin
                            state_d      = ST_SEARCH;
                            mem_opcode_d = 1'b1;
                            mem_mask_d   = '1;
                            mem_addr_d   = '0;
                            cnt_d        = CNT_W'(SEARCH_LAT - 1);
                        end
                        OP_FLUSH: begin
                            state_d     = ST_FLUSH;
                            mem_clr_d   = 1'b1;
                            mem_word_d  = '0;
                            mem_mask_d  = '0;
                            mem_addr_d  = '0;
                            valid_map_d = '0;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                state_d     = ST_RESP;
                mem_req_d   = 1'b0;
                mem_clr_d   = 1'b0;
                rsp_valid_d = 1'b1;
            end
            ST_SEARCH: begin
                if (cnt_q == '0) begin
                    // Entries never written (or cleared) may still match in the array.
                    match_vec_d = mem_matched & valid_map_q;
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (mem_addr_q == ADDR_W'(WORD_NUM - 1)) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    mem_clr_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            // NOTE: the array itself is never reset; a cleared valid_map hides whatever it still holds.
            valid_map_q  <= '0;
            match_vec_q  <= '0;
            occupancy_q  <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            mem_word_q   <= '0;
            mem_mask_q   <= '0;
            mem_addr_q   <= '0;
            mem_opcode_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_clr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_map_q  <= valid_map_d;
            match_vec_q  <= match_vec_d;
            occupancy_q  <= occupancy_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            mem_word_q   <= mem_word_d;
            mem_mask_q   <= mem_mask_d;
            mem_addr_q   <= mem_addr_d;
            mem_opcode_q <= mem_opcode_d;
            mem_req_q    <= mem_req_d;
            mem_clr_q    <= mem_clr_d;
        end
    end

    tcam_prio_enc #(
        .WORD_NUM (WORD_NUM)
    ) u_prio_enc (
        .vec_i   (match_vec_q),
        .idx_o   (rsp_idx),
        .hit_o   (rsp_hit),
        .multi_o (rsp_multi)
    );

    assign cmd_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_match_vec = match_vec_q;
    assign occupancy     = occupancy_q;
    assign mem_word      = mem_word_q;
    assign mem_mask      = mem_mask_q;
    assign mem_addr      = mem_addr_q;
    assign mem_opcode    = mem_opcode_q;
    assign mem_req       = mem_req_q;
    assign mem_clr       = mem_clr_q;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Directed bench for tcam_ctrl driving a small behavioural TCAM array model.
module tb_tcam_ctrl;
    import tcam_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_key, cmd_mask;
    logic [2:0] cmd_addr;
    logic       rsp_valid, rsp_ready, rsp_hit, rsp_multi;
    logic [2:0] rsp_idx;
    logic [7:0] rsp_match_vec;
    logic [3:0] occupancy;
    logic [7:0] mem_word, mem_mask;
    logic [2:0] mem_addr;
    logic       mem_opcode, mem_req, mem_clr;
    logic [7:0] mem_matched;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcam_ctrl #(
        .WORD_WIDTH (8),
        .WORD_NUM   (8),
        .SEARCH_LAT (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_key       (cmd_key),
        .cmd_mask      (cmd_mask),
        .cmd_addr      (cmd_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_hit       (rsp_hit),
        .rsp_multi     (rsp_multi),
        .rsp_idx       (rsp_idx),
        .rsp_match_vec (rsp_match_vec),
        .occupancy     (occupancy),
        .mem_word      (mem_word),
        .mem_mask      (mem_mask),
        .mem_addr      (mem_addr),
        .mem_opcode    (mem_opcode),
        .mem_req       (mem_req),
        .mem_clr       (mem_clr),
        .mem_matched   (mem_matched)
    );

    // Array model: stale power-up contents (mask 0) match every key.
    logic [7:0] m_word [8] = '{default: 8'h00};
    logic [7:0] m_mask [8] = '{default: 8'h00};

    always @(posedge clk) begin
        if (mem_req && !mem_opcode) begin
            if (mem_clr) begin
                m_word[mem_addr] <= 8'h00;
                m_mask[mem_addr] <= 8'h00;
            end else begin
                m_word[mem_addr] <= mem_word;
                m_mask[mem_addr] <= mem_mask;
            end
        end
    end

    always_comb begin
        mem_matched = '0;
        for (int i = 0; i < 8; i++) begin
            mem_matched[i] = (((mem_word ^ m_word[i]) & m_mask[i] & mem_mask) == 8'h00);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command in IDLE; returns in the cycle after the accepting edge.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] key,
                          input logic [7:0] mask, input logic [2:0] addr);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_mask  = mask;
        cmd_addr  = addr;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic write_entry(input logic [2:0] addr, input logic [7:0] key, input logic [7:0] mask);
        do_cmd(OP_WRITE, key, mask, addr);
        tick();
        check("write_rsp", {rsp_valid, rsp_hit, rsp_multi}, 3'b100);
        finish_rsp();
    endtask

    task automatic search(input logic [7:0] key);
        do_cmd(OP_SEARCH, key, 8'hFF, 3'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_key   = 8'h00;
        cmd_mask  = 8'h00;
        cmd_addr  = 3'd0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_bus", {mem_clr, mem_opcode, mem_addr, mem_word, mem_mask}, 0);
        check("rst_rsp", {rsp_valid, rsp_hit, rsp_multi, rsp_idx, rsp_match_vec}, 0);
        check("rst_occupancy", occupancy, 0);
        rst = 1'b0;

        // 1: stale array contents are masked by an empty valid map.
        do_cmd(OP_SEARCH, 8'h00, 8'hFF, 3'd0);
        check("t1_issue", {mem_req, mem_opcode, mem_clr, cmd_ready}, 4'b1100);
        check("t1_key", {mem_word, mem_mask}, 16'h00FF);
        tick();
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_hit", {rsp_hit, rsp_multi}, 0);
        check("t1_vec", rsp_match_vec, 8'h00);
        check("t1_occ", occupancy, 0);
        check("t1_req_low", mem_req, 0);
        finish_rsp();

        // 2: fill addrs 7..0 with 0x01..0x08, single hit at 5.
        do_cmd(OP_WRITE, 8'h01, 8'hFF, 3'd7);
        check("t2_write_issue", {mem_req, mem_opcode, mem_clr, mem_addr, mem_word, mem_mask},
              {1'b1, 1'b0, 1'b0, 3'd7, 8'h01, 8'hFF});
        tick();
        check("t2_write_rsp", {rsp_valid, rsp_hit, rsp_multi, mem_req}, 4'b1000);
        finish_rsp();
        for (int i = 1; i < 8; i++) begin
            write_entry(3'(7 - i), 8'(i + 1), 8'hFF);
        end
        search(8'h03);
        check("t2_hit", {rsp_valid, rsp_hit, rsp_multi, rsp_idx}, {3'b110, 3'd5});
        check("t2_vec", rsp_match_vec, 8'b0010_0000);
        check("t2_occ", occupancy, 8);
        finish_rsp();

        // 3: clear addr 5 pulses mem_clr for one cycle.
        do_cmd(OP_CLEAR, 8'h00, 8'h00, 3'd5);
        check("t3_clr_issue", {mem_req, mem_clr, mem_opcode, mem_addr}, {3'b110, 3'd5});
        tick();
        check("t3_clr_drop", {mem_req, mem_clr, rsp_valid}, 3'b001);
        check("t3_clr_occ", occupancy, 7);
        finish_rsp();
        search(8'h03);
        check("t3_miss", {rsp_hit, rsp_multi, rsp_idx, rsp_match_vec}, 0);
        check("t3_occ", occupancy, 7);
        finish_rsp();

        // 4: ternary entries give a double hit at 7 and 6.
        write_entry(3'd7, 8'hFC, 8'hFC);
        write_entry(3'd6, 8'hFE, 8'hFE);
        search(8'hFE);
        check("t4_vec", rsp_match_vec, 8'b1100_0000);
        check("t4_hit", {rsp_hit, rsp_multi, rsp_idx}, {2'b11, 3'd6});
        check("t4_occ_rewrite", occupancy, 7);
        finish_rsp();

        // Clearing an invalid entry leaves occupancy alone; rewriting 5 refills it.
        do_cmd(OP_CLEAR, 8'h00, 8'h00, 3'd5);
        tick();
        finish_rsp();
        check("clr_invalid_occ", occupancy, 7);
        write_entry(3'd5, 8'h03, 8'hFF);
        check("refill_occ", occupancy, 8);

        // 5: response held under back-pressure; pending command waits.
        search(8'h03);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_key   = 8'h55;
        cmd_mask  = 8'hFF;
        cmd_addr  = 3'd0;
        for (int c = 0; c < 3; c++) begin
            check("t5_hold_rsp", {rsp_valid, rsp_hit, rsp_multi, rsp_idx, rsp_match_vec},
                  {3'b110, 3'd5, 8'h20});
            check("t5_hold_ctl", {cmd_ready, mem_req}, 2'b00);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t5_after_hs", {rsp_valid, cmd_ready, mem_req}, 3'b010);
        tick();
        cmd_valid = 1'b0;
        check("t5_accepted", {mem_req, mem_addr, mem_word}, {1'b1, 3'd0, 8'h55});
        tick();
        check("t5_write_rsp", rsp_valid, 1);
        finish_rsp();

        // 6: flush walks every address, then a flush aborted by reset.
        do_cmd(OP_FLUSH, 8'h00, 8'h00, 3'd0);
        for (int k = 0; k < 8; k++) begin
            check("t6_flush_step", {mem_req, mem_clr, mem_opcode, mem_addr, rsp_valid},
                  {3'b110, 3'(k), 1'b0});
            tick();
        end
        check("t6_flush_rsp", {rsp_valid, mem_req, mem_clr}, 3'b100);
        check("t6_flush_occ", occupancy, 0);
        finish_rsp();

        do_cmd(OP_FLUSH, 8'h00, 8'h00, 3'd0);
        tick();
        tick();
        check("t6_third_cycle", {mem_req, mem_clr, mem_addr}, {2'b11, 3'd2});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_abort", {cmd_ready, mem_req, mem_clr, rsp_valid, mem_addr}, {4'b1000, 3'd0});
        search(8'h00);
        check("t6_post_rst_miss", {rsp_valid, rsp_hit, rsp_match_vec, occupancy}, {2'b10, 8'h00, 4'd0});
        finish_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
